// File: rtl/truth_table_scanner.sv
// Drives all four input combinations of a 2-input combinational block, samples its
// response after a settle time, and compares the captured truth table to an expected one.
module truth_table_scanner #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [3:0] expected,
   input  logic       resp,
   output logic       x,
   output logic       y,
   output logic       busy,
   output logic       done,
   output logic [3:0] table_out,
   output logic       match,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] index_q, index_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] exp_q, exp_d;
   logic [3:0] table_q, table_d;
   logic [2:0] err_q, err_d;
   logic       match_q, match_d;
   logic       x_q, x_d;
   logic       y_q, y_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      table_d = table_q;
      err_d   = err_q;
      match_d = match_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               index_d = 2'd0;
               cnt_d   = 4'd0;
               exp_d   = expected;
               table_d = 4'b0000;
               err_d   = 3'd0;
               match_d = 1'b0;
            end
         end
         SCAN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d            = 4'd0;
               table_d[index_q] = resp;
               // err_count can reach at most 4 with four entries; the guard keeps it there.
               if ((resp != exp_q[index_q]) && (err_q < 3'd4)) begin
                  err_d = err_q + 3'd1;
               end
               if (index_q == 2'd3) begin
                  state_d = DONE;
                  match_d = (err_d == 3'd0);
               end else begin
                  index_d = index_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next-state view so they line up with the state.
      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
      x_d    = (state_d == SCAN) & index_d[1];
      y_d    = (state_d == SCAN) & index_d[0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         index_q <= 2'd0;
         cnt_q   <= 4'd0;
         exp_q   <= 4'd0;
         table_q <= 4'd0;
         err_q   <= 3'd0;
         match_q <= 1'b0;
         x_q     <= 1'b0;
         y_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         err_q   <= err_d;
         match_q <= match_d;
         x_q     <= x_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign table_out = table_q;
   assign match     = match_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: an AND gate / stuck-at-1 reference block at
// SETTLE_CYCLES=2, plus a SETTLE_CYCLES=1 instance exercised with start held high.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // SETTLE_CYCLES = 2 instance
   logic       rst_n, start, resp, stuck;
   logic [3:0] expected;
   logic       x, y, busy, done, match;
   logic [3:0] table_out;
   logic [2:0] err_count;

   assign resp = stuck ? 1'b1 : (x & y);

   truth_table_scanner #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .reset_n(rst_n), .start(start), .expected(expected), .resp(resp),
      .x(x), .y(y), .busy(busy), .done(done), .table_out(table_out),
      .match(match), .err_count(err_count)
   );

   // SETTLE_CYCLES = 1 instance
   logic       rst1_n, start1, resp1;
   logic [3:0] expected1;
   logic       x1, y1, busy1, done1, match1;
   logic [3:0] table1;
   logic [2:0] err1;

   assign resp1 = x1 & y1;

   truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(rst1_n), .start(start1), .expected(expected1), .resp(resp1),
      .x(x1), .y(y1), .busy(busy1), .done(done1), .table_out(table1),
      .match(match1), .err_count(err1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      logic       stuck;
      logic [3:0] exp;
      logic [3:0] tbl;
      logic [2:0] err;
      logic       mt;
   } vec_t;

   vec_t vecs[5];

   // One scan on the SETTLE_CYCLES=2 instance; optionally disturbs start/expected mid-scan.
   task automatic run_scan(input string nm, input logic [3:0] exp_v, input logic [3:0] tbl,
                           input logic [2:0] errv, input logic mt, input bit disturb);
      int dones = 0;
      expected = exp_v;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s xy%0d", nm, k), {30'd0, x, y}, k / 2);
         chk($sformatf("%s busy%0d", nm, k), busy, 1);
         if (done) dones++;
         if (disturb && k == 2) begin
            start    = 1'b1;
            expected = ~exp_v;
         end
         if (disturb && k == 3) start = 1'b0;
         tick();
      end
      chk({nm, " done"}, done, 1);
      chk({nm, " busy_done"}, busy, 0);
      chk({nm, " xy_done"}, {x, y}, 0);
      chk({nm, " table"}, table_out, tbl);
      chk({nm, " err"}, err_count, errv);
      chk({nm, " match"}, match, mt);
      if (done) dones++;
      tick();
      chk({nm, " done_low"}, done, 0);
      chk({nm, " busy_idle"}, busy, 0);
      chk({nm, " table_hold"}, table_out, tbl);
      chk({nm, " err_hold"}, err_count, errv);
      chk({nm, " match_hold"}, match, mt);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done) dones++;
      end
      chk({nm, " done_count"}, dones, 1);
      expected = exp_v;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"and_ok",    1'b0, 4'b1000, 4'b1000, 3'd0, 1'b1};
      vecs[1] = '{"and_1110",  1'b0, 4'b1110, 4'b1000, 3'd2, 1'b0};
      vecs[2] = '{"stuck_0000",1'b1, 4'b0000, 4'b1111, 3'd4, 1'b0};
      vecs[3] = '{"stuck_1111",1'b1, 4'b1111, 4'b1111, 3'd0, 1'b1};
      vecs[4] = '{"and_0000",  1'b0, 4'b0000, 4'b1000, 3'd1, 1'b0};

      rst_n = 1'b0; start = 1'b1; stuck = 1'b0; expected = 4'b1000;
      rst1_n = 1'b0; start1 = 1'b0; expected1 = 4'b1000;
      tick();
      tick();
      // start was high during reset: reset must win
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst xy", {x, y}, 0);
      chk("rst table", table_out, 0);
      chk("rst err", err_count, 0);
      chk("rst match", match, 0);

      // first edge with reset released also accepts start
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         stuck = vecs[i].stuck;
         run_scan(vecs[i].name, vecs[i].exp, vecs[i].tbl, vecs[i].err, vecs[i].mt, 1'b0);
      end

      // reset during the third combination; stuck-at-1 leaves a nonzero partial table
      stuck    = 1'b1;
      expected = 4'b0000;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("mid xy_before", {x, y}, 2);
      chk("mid partial", table_out, 4'b0011);
      rst_n = 1'b0;
      tick();
      chk("mid_rst busy", busy, 0);
      chk("mid_rst xy", {x, y}, 0);
      chk("mid_rst table", table_out, 0);
      chk("mid_rst err", err_count, 0);
      chk("mid_rst match", match, 0);
      chk("mid_rst done", done, 0);
      rst_n = 1'b1;
      stuck = 1'b0;
      run_scan("after_rst", 4'b1000, 4'b1000, 3'd0, 1'b1, 1'b0);

      // start pulse and expected change mid-scan must not disturb the scan
      run_scan("disturb", 4'b1000, 4'b1000, 3'd0, 1'b1, 1'b1);

      // back-to-back scans at SETTLE_CYCLES=1: 4 scan cycles, one DONE, one IDLE
      rst1_n = 1'b1;
      start1 = 1'b1;
      for (int c = 0; c < 18; c++) begin
         tick();
         chk($sformatf("b2b done c%0d", c), done1, (c % 6) == 4);
         chk($sformatf("b2b busy c%0d", c), busy1, (c % 6) < 4);
         if ((c % 6) < 4) chk($sformatf("b2b xy c%0d", c), {x1, y1}, c % 6);
         else             chk($sformatf("b2b xy0 c%0d", c), {x1, y1}, 0);
      end
      chk("b2b table", table1, 4'b1000);
      chk("b2b err", err1, 0);
      chk("b2b match", match1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
